// File: rtl/difftest_lrsc_event_arbiter.sv
// Buffers per-core LR/SC completion events in small FIFOs and
// serializes them round-robin onto the single LrScEvent sink.
//
// Ports:
//   clock, reset_n     : rising-edge clock, async active-low reset
//   in_valid[N]        : per-core event strobe
//   in_success[N]      : per-core SC success bit, sampled with in_valid
//   flush              : synchronous clear of FIFOs and output register
//   out_ready          : sink accepts the presented event
//   out_enable         : event present (sink enable)
//   out_valid          : mirror of out_enable
//   out_success        : success bit of the presented event
//   out_coreid         : CORE_BASE + source core index (8-bit)
//   overflow[N]        : sticky per-core dropped-event flag
//   drop_cnt[N*CNT_W]  : per-core saturating drop counters
module difftest_lrsc_event_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CORE_BASE  = 0,
  parameter int CNT_W      = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_CORES-1:0]       in_valid,
  input  logic [NUM_CORES-1:0]       in_success,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_enable,
  output logic                       out_valid,
  output logic                       out_success,
  output logic [7:0]                 out_coreid,
  output logic [NUM_CORES-1:0]       overflow,
  output logic [NUM_CORES*CNT_W-1:0] drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(NUM_CORES);

  // FIFO storage and pointers, one set per core
  logic [FIFO_DEPTH-1:0] r_mem [NUM_CORES];
  logic [PW-1:0]         r_wp  [NUM_CORES];
  logic [PW-1:0]         r_rp  [NUM_CORES];
  logic [CW-1:0]         r_cnt [NUM_CORES];
  logic [CNT_W-1:0]      r_drop[NUM_CORES];
  logic [NUM_CORES-1:0]  r_ovf;

  // Round-robin pointer and output register
  logic [RW-1:0] r_rr;
  logic          r_out_en;
  logic          r_out_succ;
  logic [7:0]    r_out_id;

  logic [NUM_CORES-1:0] w_empty;
  logic [NUM_CORES-1:0] w_full;
  logic [NUM_CORES-1:0] w_push;
  logic [NUM_CORES-1:0] w_pop;
  logic [NUM_CORES-1:0] w_drop;
  logic                 w_load;
  logic                 w_found;
  logic [RW-1:0]        w_idx;
  logic                 w_head;

  function automatic logic [RW-1:0] f_wrap(input int v);
    return RW'(v % NUM_CORES);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      w_empty[i] = (r_cnt[i] == '0);
      w_full[i]  = (r_cnt[i] == CW'(FIFO_DEPTH));
    end
  end

  // Output register takes a new event when empty or being consumed
  assign w_load = !r_out_en || out_ready;

  // First non-empty FIFO at or after the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!w_found && !w_empty[f_wrap(int'(r_rr) + k)]) begin
        w_found = 1'b1;
        w_idx   = f_wrap(int'(r_rr) + k);
      end
    end
  end

  assign w_head = r_mem[w_idx][r_rp[w_idx]];

  // A full FIFO still accepts a push when its head leaves this cycle
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      w_pop[i]  = !flush && w_load && w_found &&
                  (w_idx == RW'(i));
      w_push[i] = !flush && in_valid[i] &&
                  (!w_full[i] || w_pop[i]);
      w_drop[i] = !flush && in_valid[i] &&
                  w_full[i] && !w_pop[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r_mem[i]  <= '0;
        r_wp[i]   <= '0;
        r_rp[i]   <= '0;
        r_cnt[i]  <= '0;
        r_drop[i] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (flush) begin
          r_wp[i]  <= '0;
          r_rp[i]  <= '0;
          r_cnt[i] <= '0;
        end else begin
          if (w_push[i]) begin
            r_mem[i][r_wp[i]] <= in_success[i];
            r_wp[i] <= r_wp[i] + PW'(1);
          end
          if (w_pop[i]) begin
            r_rp[i] <= r_rp[i] + PW'(1);
          end
          unique case ({w_push[i], w_pop[i]})
            2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
            2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
            default: ;
          endcase
        end
        if (w_drop[i]) begin
          r_ovf[i] <= 1'b1;
          if (r_drop[i] != '1) begin
            r_drop[i] <= r_drop[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr       <= '0;
      r_out_en   <= 1'b0;
      r_out_succ <= 1'b0;
      r_out_id   <= '0;
    end else if (flush) begin
      r_out_en   <= 1'b0;
      r_out_succ <= 1'b0;
      r_out_id   <= '0;
    end else if (w_load) begin
      r_out_en <= w_found;
      if (w_found) begin
        r_out_succ <= w_head;
        r_out_id   <= 8'(CORE_BASE + int'(w_idx));
        r_rr       <= f_wrap(int'(w_idx) + 1);
      end else begin
        r_out_succ <= 1'b0;
        r_out_id   <= '0;
      end
    end
  end

  assign out_enable  = r_out_en;
  assign out_valid   = r_out_en;
  assign out_success = r_out_succ;
  assign out_coreid  = r_out_id;
  assign overflow    = r_ovf;

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      drop_cnt[i*CNT_W +: CNT_W] = r_drop[i];
    end
  end

endmodule

// File: tb/tb_difftest_lrsc_event_arbiter.sv
// Scenario bench for difftest_lrsc_event_arbiter: expected sink
// events are queued at stimulus time and checked at acceptance.
module tb_difftest_lrsc_event_arbiter;

  localparam int N = 4;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_success = '0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_enable;
  logic         out_valid;
  logic         out_success;
  logic [7:0]   out_coreid;
  logic [N-1:0] overflow;
  logic [N*CW-1:0] drop_cnt;

  int n_chk = 0;
  int n_pass = 0;
  bit sb_on = 1'b1;
  logic [8:0] exp_q[$];
  logic [8:0] mon_ev;

  difftest_lrsc_event_arbiter #(
    .NUM_CORES(N), .FIFO_DEPTH(4),
    .CORE_BASE(0), .CNT_W(CW)
  ) dut (
    .clock(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_success(in_success),
    .flush(flush), .out_ready(out_ready),
    .out_enable(out_enable), .out_valid(out_valid),
    .out_success(out_success), .out_coreid(out_coreid),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1);
  end

  // Scoreboard: an event is consumed when enable & ready at an edge
  always @(negedge clk) begin
    if (sb_on && reset_n && out_enable && out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_extra: got succ=%0b id=%0d, required none",
                 out_success, out_coreid);
      end else begin
        mon_ev = exp_q.pop_front();
        if ({out_valid, out_success, out_coreid} !== {1'b1, mon_ev})
          $display("FAIL sb_event: got v=%0b succ=%0b id=%0d, required v=1 succ=%0b id=%0d",
                   out_valid, out_success, out_coreid,
                   mon_ev[8], mon_ev[7:0]);
        else n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = '0;
    in_success = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_drain(input string nm);
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_enable) && cyc < 60) begin
      step();
      cyc++;
    end
    n_chk++;
    if (exp_q.size() != 0 || out_enable)
      $display("FAIL %s_drain: got %0d pending, required 0",
               nm, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({out_enable, out_valid, out_success, out_coreid} !== 11'd0)
      $display("FAIL reset_out: got en=%0b v=%0b s=%0b id=%0d, required 0",
               out_enable, out_valid, out_success, out_coreid);
    else n_pass++;
    n_chk++;
    if (overflow !== 4'b0000)
      $display("FAIL reset_ovf: got %b, required 0000", overflow);
    else n_pass++;
    n_chk++;
    if (drop_cnt !== 8'h00)
      $display("FAIL reset_drop: got %h, required 00", drop_cnt);
    else n_pass++;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 4'b0100;
    in_success = 4'b0100;
    exp_q.push_back({1'b1, 8'd2});
    step();
    in_valid = '0;
    in_success = '0;
    n_chk++;
    if (out_enable !== 1'b0)
      $display("FAIL single_nobypass: got %0b, required 0", out_enable);
    else n_pass++;
    step();
    n_chk++;
    if ({out_enable, out_success, out_coreid} !== {1'b1, 1'b1, 8'd2})
      $display("FAIL single_out: got en=%0b s=%0b id=%0d, required 1 1 2",
               out_enable, out_success, out_coreid);
    else n_pass++;
    step();
    n_chk++;
    if (out_enable !== 1'b0)
      $display("FAIL single_once: got %0b, required 0", out_enable);
    else n_pass++;
    wait_drain("single");
  endtask

  task automatic burst(input logic [3:0] succ, input string nm);
    out_ready = 1'b1;
    in_valid = 4'hF;
    in_success = succ;
    step();
    in_valid = '0;
    in_success = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_chk++;
      if (out_enable !== 1'b1)
        $display("FAIL %s_b2b%0d: got en=%0b, required 1", nm, k, out_enable);
      else n_pass++;
    end
    step();
    n_chk++;
    if (out_enable !== 1'b0)
      $display("FAIL %s_end: got en=%0b, required 0", nm, out_enable);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    exp_q.push_back({1'b1, 8'd0});
    exp_q.push_back({1'b0, 8'd1});
    exp_q.push_back({1'b0, 8'd2});
    exp_q.push_back({1'b1, 8'd3});
    burst(4'b1001, "rr0");
    wait_drain("rr0");
    // a lone core-0 grant moves the pointer to 1
    in_valid = 4'b0001;
    exp_q.push_back({1'b0, 8'd0});
    step();
    in_valid = '0;
    wait_drain("rr_mid");
    exp_q.push_back({1'b1, 8'd1});
    exp_q.push_back({1'b1, 8'd2});
    exp_q.push_back({1'b0, 8'd3});
    exp_q.push_back({1'b0, 8'd0});
    burst(4'b0110, "rr1");
    wait_drain("rr1");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 4'b0001;
    in_success = 4'b0001;
    exp_q.push_back({1'b1, 8'd0});
    step();
    in_success = 4'b0000;
    exp_q.push_back({1'b0, 8'd0});
    step();
    in_valid = '0;
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if ({out_enable, out_success, out_coreid} !== {1'b1, 1'b1, 8'd0})
        $display("FAIL bp_hold%0d: got en=%0b s=%0b id=%0d, required 1 1 0",
                 k, out_enable, out_success, out_coreid);
      else n_pass++;
      step();
    end
    wait_drain("bp");
  endtask

  task automatic test_overflow();
    logic [5:0] pat;
    do_reset();
    pat = 6'b101101;
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 4'b0010;
      in_success = {2'b00, pat[k], 1'b0};
      if (k < 5) exp_q.push_back({pat[k], 8'd1});
      step();
    end
    in_valid = '0;
    n_chk++;
    if (overflow !== 4'b0010)
      $display("FAIL ovf_flag: got %b, required 0010", overflow);
    else n_pass++;
    n_chk++;
    if (drop_cnt !== 8'h04)
      $display("FAIL ovf_cnt: got %h, required 04", drop_cnt);
    else n_pass++;
    // full FIFO popped in the same cycle still takes the push
    out_ready = 1'b1;
    in_valid = 4'b0010;
    in_success = 4'b0010;
    exp_q.push_back({1'b1, 8'd1});
    step();
    in_valid = '0;
    in_success = '0;
    n_chk++;
    if (drop_cnt !== 8'h04)
      $display("FAIL ovf_poppush: got %h, required 04", drop_cnt);
    else n_pass++;
    wait_drain("ovf");
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 4'b1000;
      in_success = {k[0], 3'b000};
      if (k < 5) exp_q.push_back({k[0], 8'd3});
      step();
      if (k == 6) begin
        n_chk++;
        if (drop_cnt[6 +: 2] !== 2'd2)
          $display("FAIL sat_mid: got %0d, required 2", drop_cnt[6 +: 2]);
        else n_pass++;
      end
    end
    in_valid = '0;
    in_success = '0;
    n_chk++;
    if (drop_cnt !== 8'hC4)
      $display("FAIL sat_cnt: got %h, required c4", drop_cnt);
    else n_pass++;
    n_chk++;
    if (overflow !== 4'b1010)
      $display("FAIL sat_ovf: got %b, required 1010", overflow);
    else n_pass++;
    wait_drain("sat");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 4'b0100;
    in_success = 4'b0100;
    repeat (4) step();
    n_chk++;
    if (out_enable !== 1'b1)
      $display("FAIL flush_pre: got en=%0b, required 1", out_enable);
    else n_pass++;
    flush = 1'b1;
    in_valid = 4'b0001;
    in_success = 4'b0001;
    step();
    flush = 1'b0;
    in_valid = '0;
    in_success = '0;
    n_chk++;
    if (out_enable !== 1'b0)
      $display("FAIL flush_out: got en=%0b, required 0", out_enable);
    else n_pass++;
    n_chk++;
    if ({overflow, drop_cnt} !== {4'b1010, 8'hC4})
      $display("FAIL flush_keep: got ovf=%b cnt=%h, required 1010 c4",
               overflow, drop_cnt);
    else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (out_enable !== 1'b0)
        $display("FAIL flush_empty%0d: got en=%0b, required 0", k, out_enable);
      else n_pass++;
    end
    in_valid = 4'b0010;
    exp_q.push_back({1'b0, 8'd1});
    step();
    in_valid = '0;
    wait_drain("flush");
  endtask

  task automatic test_async_reset();
    sb_on = 1'b0;
    out_ready = 1'b1;
    in_valid = 4'hF;
    in_success = 4'b0101;
    repeat (3) step();
    n_chk++;
    if (out_enable !== 1'b1)
      $display("FAIL arst_pre: got en=%0b, required 1", out_enable);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({out_enable, out_valid, out_success, out_coreid,
         overflow, drop_cnt} !== 23'd0)
      $display("FAIL arst_now: got en=%0b s=%0b id=%0d ovf=%b cnt=%h, required all 0",
               out_enable, out_success, out_coreid, overflow, drop_cnt);
    else n_pass++;
    in_valid = '0;
    in_success = '0;
    repeat (2) step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (out_enable !== 1'b0)
        $display("FAIL arst_empty%0d: got en=%0b, required 0", k, out_enable);
      else n_pass++;
    end
    exp_q.delete();
    sb_on = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_saturation();
    test_flush();
    test_async_reset();
    n_chk++;
    if (exp_q.size() != 0)
      $display("FAIL sb_left: got %0d, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
